// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID-stage opcode and carries WB/M/EX bundles through ID/EX, EX/MEM, MEM/WB.
// Optional macro CTRL_ADDI_EN adds addi decode; load-use stall, branch flush and illegal-opcode flag included.
module pipelined_control_unit #(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned HAZARD_DET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] I,
    input  logic               branch_taken,
    output logic               stall,
    output logic [3:0]         ex_ctrl,
    output logic [2:0]         mem_ctrl,
    output logic [1:0]         wb_ctrl,
    output logic               illegal_op
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  unused_low_bits;

    assign opcode          = I[INSTR_W-1 -: 6];
    assign rs              = I[INSTR_W-7 -: REG_ADDR_W];
    assign rt              = I[INSTR_W-7-REG_ADDR_W -: REG_ADDR_W];
    assign unused_low_bits = ^I[INSTR_W-7-2*REG_ADDR_W:0];

    logic [1:0] dec_wb;
    logic [2:0] dec_m;
    logic [3:0] dec_ex;
    logic       dec_ill;
    logic       uses_rt;

    always_comb begin
        dec_wb  = '0;
        dec_m   = '0;
        dec_ex  = '0;
        dec_ill = 1'b0;
        uses_rt = 1'b0;
        if (instr_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    dec_wb  = 2'b10;
                    dec_ex  = 4'b1100;
                    uses_rt = 1'b1;
                end
                OP_LW: begin
                    dec_wb = 2'b11;
                    dec_m  = 3'b010;
                    dec_ex = 4'b0001;
                end
                OP_SW: begin
                    dec_m   = 3'b001;
                    dec_ex  = 4'b0001;
                    uses_rt = 1'b1;
                end
                OP_BEQ: begin
                    dec_m   = 3'b100;
                    dec_ex  = 4'b0010;
                    uses_rt = 1'b1;
                end
`ifdef CTRL_ADDI_EN
                OP_ADDI: begin
                    dec_wb = 2'b10;
                    dec_ex = 4'b0001;
                end
`endif
                default: dec_ill = 1'b1;
            endcase
        end
    end

    logic [1:0]            idex_wb;
    logic [2:0]            idex_m;
    logic [3:0]            idex_ex;
    logic [REG_ADDR_W-1:0] idex_rt;
    logic [1:0]            exmem_wb;
    logic [2:0]            exmem_m;
    logic [1:0]            memwb_wb;
    logic                  hazard;

    // Only the load in EX can create a load-use hazard; a taken branch discards ID anyway.
    assign hazard = idex_m[1] && instr_valid && !branch_taken &&
                    ((idex_rt == rs) || ((idex_rt == rt) && uses_rt));
    assign stall  = (HAZARD_DET != 0) ? hazard : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_wb    <= '0;
            idex_m     <= '0;
            idex_ex    <= '0;
            idex_rt    <= '0;
            illegal_op <= 1'b0;
            exmem_wb   <= '0;
            exmem_m    <= '0;
            memwb_wb   <= '0;
        end else if (branch_taken) begin
            idex_wb    <= '0;
            idex_m     <= '0;
            idex_ex    <= '0;
            idex_rt    <= '0;
            illegal_op <= 1'b0;
            exmem_wb   <= '0;
            exmem_m    <= '0;
            memwb_wb   <= exmem_wb;
        end else begin
            if (stall) begin
                idex_wb    <= '0;
                idex_m     <= '0;
                idex_ex    <= '0;
                idex_rt    <= '0;
                illegal_op <= 1'b0;
            end else begin
                idex_wb    <= dec_wb;
                idex_m     <= dec_m;
                idex_ex    <= dec_ex;
                idex_rt    <= rt;
                illegal_op <= dec_ill;
            end
            exmem_wb <= idex_wb;
            exmem_m  <= idex_m;
            memwb_wb <= exmem_wb;
        end
    end

    assign ex_ctrl  = idex_ex;
    assign mem_ctrl = exmem_m;
    assign wb_ctrl  = memwb_wb;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: directed rows queue hand-computed expectations for a negedge monitor.
// Expectations for opcode 001000 follow the CTRL_ADDI_EN macro.
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] I;
    logic        branch_taken;
    logic        stall;
    logic [3:0]  ex_ctrl;
    logic [2:0]  mem_ctrl;
    logic [1:0]  wb_ctrl;
    logic        illegal_op;

    always #5 clk = ~clk;

    pipelined_control_unit #(
        .INSTR_W(32),
        .REG_ADDR_W(5),
        .HAZARD_DET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .instr_valid(instr_valid),
        .I(I),
        .branch_taken(branch_taken),
        .stall(stall),
        .ex_ctrl(ex_ctrl),
        .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl),
        .illegal_op(illegal_op)
    );

    localparam logic [31:0] LW   = 32'h8C220004;  // rs=1 rt=2
    localparam logic [31:0] ADD2 = 32'h00421820;  // rs=2 rt=2
    localparam logic [31:0] ADDN = 32'h00C74020;  // rs=6 rt=7
    localparam logic [31:0] SW   = 32'hACA20000;  // rs=5 rt=2
    localparam logic [31:0] ADDI = 32'h20A20000;  // rs=5 rt=2
    localparam logic [31:0] BEQ  = 32'h10640000;  // rs=3 rt=4
    localparam logic [31:0] ILL  = 32'hFC000000;

`ifdef CTRL_ADDI_EN
    localparam logic [3:0] ADDI_EX  = 4'b0001;
    localparam logic       ADDI_ILL = 1'b0;
    localparam logic [1:0] ADDI_WB  = 2'b10;
`else
    localparam logic [3:0] ADDI_EX  = 4'b0000;
    localparam logic       ADDI_ILL = 1'b1;
    localparam logic [1:0] ADDI_WB  = 2'b00;
`endif

    typedef struct {
        int          idx;
        logic        r;
        logic        v;
        logic [31:0] ins;
        logic        bt;
        logic [3:0]  ex;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic        ill;
        logic        st;
    } vec_t;

    vec_t vecs[$];
    vec_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic v, input logic [31:0] ins, input logic bt,
                       input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                       input logic ill, input logic st);
        vec_t e;
        e.idx = vecs.size();
        e.r = r; e.v = v; e.ins = ins; e.bt = bt;
        e.ex = ex; e.mem = mem; e.wb = wb; e.ill = ill; e.st = st;
        vecs.push_back(e);
    endtask

    task automatic nop(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                       input logic ill);
        add(1'b0, 1'b0, 32'h0, 1'b0, ex, mem, wb, ill, 1'b0);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL row %0d %s: got %b expected %b", idx, name, got, want);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            vec_t e;
            e = expq.pop_front();
            chk("ex_ctrl",    e.idx, ex_ctrl,                   e.ex);
            chk("mem_ctrl",   e.idx, {1'b0, mem_ctrl},          {1'b0, e.mem});
            chk("wb_ctrl",    e.idx, {2'b00, wb_ctrl},          {2'b00, e.wb});
            chk("illegal_op", e.idx, {3'b000, illegal_op},      {3'b000, e.ill});
            chk("stall",      e.idx, {3'b000, stall},           {3'b000, e.st});
        end
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; I = '0; branch_taken = 1'b0;

        // lw latency
        add(0, 1, LW, 0,   4'b0000, 3'b000, 2'b00, 0, 0);
        nop(4'b0001, 3'b000, 2'b00, 0);
        nop(4'b0000, 3'b010, 2'b00, 0);
        nop(4'b0000, 3'b000, 2'b11, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        // lw then dependent R-type (rs match): one stall, bubble, re-decode
        add(0, 1, LW, 0,   4'b0000, 3'b000, 2'b00, 0, 0);
        add(0, 1, ADD2, 0, 4'b0001, 3'b000, 2'b00, 0, 1);
        add(0, 1, ADD2, 0, 4'b0000, 3'b010, 2'b00, 0, 0);
        nop(4'b1100, 3'b000, 2'b11, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        nop(4'b0000, 3'b000, 2'b10, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        // lw then sw with rt match
        add(0, 1, LW, 0,   4'b0000, 3'b000, 2'b00, 0, 0);
        add(0, 1, SW, 0,   4'b0001, 3'b000, 2'b00, 0, 1);
        add(0, 1, SW, 0,   4'b0000, 3'b010, 2'b00, 0, 0);
        nop(4'b0001, 3'b000, 2'b11, 0);
        nop(4'b0000, 3'b001, 2'b00, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        // lw then addi: rt is not a source, no stall
        add(0, 1, LW, 0,   4'b0000, 3'b000, 2'b00, 0, 0);
        add(0, 1, ADDI, 0, 4'b0001, 3'b000, 2'b00, 0, 0);
        nop(ADDI_EX, 3'b010, 2'b00, ADDI_ILL);
        nop(4'b0000, 3'b000, 2'b11, 0);
        nop(4'b0000, 3'b000, ADDI_WB, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        // beq, R, R with branch_taken while beq is in MEM
        add(0, 1, BEQ, 0,  4'b0000, 3'b000, 2'b00, 0, 0);
        add(0, 1, ADDN, 0, 4'b0010, 3'b000, 2'b00, 0, 0);
        add(0, 1, ADDN, 1, 4'b1100, 3'b100, 2'b00, 0, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        // flush beats a pending load-use stall
        add(0, 1, LW, 0,   4'b0000, 3'b000, 2'b00, 0, 0);
        add(0, 1, ADD2, 1, 4'b0001, 3'b000, 2'b00, 0, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        // illegal opcode, then lw decodes normally; invalid illegal opcode is silent
        add(0, 1, ILL, 0,  4'b0000, 3'b000, 2'b00, 0, 0);
        add(0, 1, LW, 0,   4'b0000, 3'b000, 2'b00, 1, 0);
        nop(4'b0001, 3'b000, 2'b00, 0);
        nop(4'b0000, 3'b010, 2'b00, 0);
        add(0, 0, ILL, 0,  4'b0000, 3'b000, 2'b11, 0, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        // reset mid-flight discards lw and R-type
        add(0, 1, LW, 0,   4'b0000, 3'b000, 2'b00, 0, 0);
        add(0, 1, ADDN, 0, 4'b0001, 3'b000, 2'b00, 0, 0);
        add(1, 1, ADDN, 0, 4'b1100, 3'b010, 2'b00, 0, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);
        nop(4'b0000, 3'b000, 2'b00, 0);

        repeat (2) @(posedge clk);
        foreach (vecs[k]) begin
            #1;
            rst          = vecs[k].r;
            instr_valid  = vecs[k].v;
            I            = vecs[k].ins;
            branch_taken = vecs[k].bt;
            expq.push_back(vecs[k]);
            @(posedge clk);
        end
        for (int n = 0; n < 10 && expq.size() != 0; n++) @(posedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Pipelined successor to the single-stage opcode decoder.
- Decodes the ID-stage instruction into WB/M/EX control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers.
- Adds load-use hazard detection (stall plus bubble), branch flush and illegal-opcode flagging.
- Sits beside the datapath pipeline registers and drives each stage's control inputs directly.

Parameters:
- INSTR_W, 32: instruction width; opcode = I[INSTR_W-1:INSTR_W-6].
- REG_ADDR_W, 5: register-specifier width; rs = I[25:21], rt = I[20:16] at defaults.
- HAZARD_DET, 1: 1 = load-use stall logic present; 0 = stall tied 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  I holds a valid ID-stage instruction.
- I  in  INSTR_W  ID-stage instruction.
- branch_taken  in  1  branch resolved taken in MEM this cycle.
- stall  out  1  combinational; hold PC and IF/ID.
- ex_ctrl  out  4  {RegDst, ALUOp[1:0], ALUSrc}, from the ID/EX register.
- mem_ctrl  out  3  {Branch, MemRead, MemWrite}, from the EX/MEM register.
- wb_ctrl  out  2  {RegWrite, MemtoReg}, from the MEM/WB register.
- illegal_op  out  1  registered; ID instruction had an undecoded opcode.

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset: every control register, ex_ctrl, mem_ctrl, wb_ctrl and illegal_op = 0; stall = 0 while the pipeline holds only bubbles.
- Decode (combinational, instr_valid=1), as WB/M/EX:
  - 000000 R-type: 10 / 000 / 1100.
  - 100011 lw: 11 / 010 / 0001.
  - 101011 sw: 00 / 001 / 0001.
  - 000100 beq: 00 / 100 / 0010.
- Don't-cares resolve to 0.
- instr_valid=0 or any other opcode: all-zero bubble; no latching of previous values.
- illegal_op <= instr_valid && opcode undecoded, for one cycle, aligned with ex_ctrl.
- Latency: bundle decoded in cycle n appears on ex_ctrl at n+1, mem_ctrl at n+2, wb_ctrl at n+3.
  - ID/EX holds the WB, M and EX parts.
  - EX/MEM holds WB and M.
  - MEM/WB holds WB.
- ID/EX also stores rt as idex_rt.
- Hazard (HAZARD_DET=1): stall = idex M.MemRead && instr_valid && !branch_taken && match.
  - match = (idex_rt == rs) || (idex_rt == rt && opcode in {R-type, sw, beq}).
  - Register 0 is not special-cased.
- Stall cycle: ID/EX <= bubble (all 0, illegal_op 0); EX/MEM and MEM/WB advance normally. The same ID instruction is re-decoded the next cycle with the hazard cleared.
- Flush: branch_taken=1 forces ID/EX <= 0 and EX/MEM <= 0 next edge. MEM/WB still captures EX/MEM (the branch's WB=00).
- Priority: rst > branch_taken > stall > normal advance.
- Reset mid-operation: all in-flight bundles are discarded at the reset edge; outputs read 0 the following cycle.
- Decode is a pure function of I; no state beyond the pipeline registers.

Optional Feature:
- Macro: CTRL_ADDI_EN.
- Defined: opcode 001000 (addi) decodes to WB=10, M=000, EX=0001. rt is not a source for the hazard match; only rs is compared.
- Undefined: 001000 is illegal (bubble, illegal_op=1).

Test Plan:
- Reset, then lw (0x8C220004) with instr_valid=1 at cycle 0:
  - ex_ctrl=0001 at cycle 1.
  - mem_ctrl=010 at cycle 2.
  - wb_ctrl=11 at cycle 3.
  - stall=0 throughout.
- lw writing rt=2, then R-type add 0x00421820 (rs=2):
  - stall=1 for exactly one cycle.
  - ex_ctrl=0000 in the bubble cycle.
  - Then ex_ctrl=1100, with wb_ctrl=10 three cycles after the re-decode.
- lw rt=2, then sw with rt=2, rs=5: stall=1 (rt match, sw). Repeat with addi rt=2, rs=5 under CTRL_ADDI_EN: stall=0.
- Sequence beq, R, R, with branch_taken=1 pulsed when beq is in MEM:
  - mem_ctrl=000 and ex_ctrl=0000 the next cycle.
  - wb_ctrl=00.
  - No R-type WB=10 ever reaches wb_ctrl.
- Opcode 111111 with instr_valid=1:
  - illegal_op=1 for one cycle.
  - ex_ctrl=0000.
  - Subsequent valid lw decodes normally.
- Assert rst for one cycle while lw/R-type are in flight: all outputs 0 on the cycle after, and no stale bundle emerges in later cycles.
